glitc_align_ctrl: RTL and testbench

- Parametrised automatic input-alignment controller for NCH GLITC data-path channels.
- Sequentially per channel:
  - scans all IDELAY taps and picks the centre of the longest stable window;
  - bitslips the ISERDES until the training pattern is seen.
- Drives the per-channel delay/load/bitslip controls that the data paths then synchronise into their own clock domains.
- Replaces manual software tap/bitslip scanning.
- Runs entirely in the clk_i domain; SERDES words arrive already resynchronised.

---
 rtl/glitc_align_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_glitc_align_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_align_ctrl.sv
// glitc_align_ctrl
//   Automatic input-alignment controller for the GLITC data-path channels.
//   Channels are calibrated one after another:
//     1. Every IDELAY tap is scanned. The longest run of taps with a stable
//        word is found, and its centre tap is loaded.
//     2. The ISERDES is bitslipped until the training PATTERN appears.
//   Everything runs in the clk_i domain. The SERDES words arrive already
//   resynchronised.
//
// Ports
//   clk_i          control clock
//   rst_n_clk_i    asynchronous active-low reset
//   start_clk_i    single-cycle start pulse (ignored while busy)
//   data_clk_i     SERDES words, channel c at [c*NBITS +: NBITS]
//   delay_clk_o    IDELAY tap value, shared by all channels
//   load_clk_o     one-hot IDELAY load strobe
//   bitslip_clk_o  one-hot bitslip strobe
//   busy_clk_o     calibration in progress
//   done_clk_o     calibration complete, sticky until the next accepted start
//   fail_clk_o     per-channel failure flags
//   tap_clk_o      chosen tap per channel, channel c at [c*TAPBITS +: TAPBITS]
module glitc_align_ctrl #(
  parameter int               NCH     = 4,
  parameter int               NBITS   = 4,
  parameter int               TAPBITS = 5,
  parameter logic [NBITS-1:0] PATTERN = 4'b1010,
  parameter int               SETTLE  = 16,
  parameter int               SAMPLES = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_clk_i,
  input  logic                     start_clk_i,
  input  logic [NCH*NBITS-1:0]     data_clk_i,
  output logic [TAPBITS-1:0]       delay_clk_o,
  output logic [NCH-1:0]           load_clk_o,
  output logic [NCH-1:0]           bitslip_clk_o,
  output logic                     busy_clk_o,
  output logic                     done_clk_o,
  output logic [NCH-1:0]           fail_clk_o,
  output logic [NCH*TAPBITS-1:0]   tap_clk_o
);

  localparam int CHW  = (NCH > 1)     ? $clog2(NCH)     : 1;
  localparam int SETW = (SETTLE > 1)  ? $clog2(SETTLE)  : 1;
  localparam int SMPW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int SLPW = (NBITS > 1)   ? $clog2(NBITS)   : 1;

  localparam logic [CHW-1:0]     LAST_CH  = CHW'(NCH - 1);
  localparam logic [TAPBITS-1:0] LAST_TAP = '1;
  localparam logic [SETW-1:0]    SET_END  = SETW'(SETTLE - 1);
  localparam logic [SMPW-1:0]    SMP_END  = SMPW'(SAMPLES - 1);
  localparam logic [SLPW-1:0]    SLP_END  = SLPW'(NBITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_CENTER, S_SCHK, S_SLIP, S_NEXT, S_DONE
  } state_t;

  state_t             state;
  logic [CHW-1:0]     ch;
  logic [TAPBITS-1:0] tap;
  logic               slip_ph;
  logic [SLPW-1:0]    slip_cnt;
  logic [SETW-1:0]    set_cnt;
  logic [SMPW-1:0]    smp_cnt;
  logic [NBITS-1:0]   w0;
  logic               ok;
  logic [TAPBITS-1:0] cur_start;
  logic [TAPBITS:0]   cur_len;
  logic [TAPBITS-1:0] best_start;
  logic [TAPBITS:0]   best_len;

  logic [NBITS-1:0]   word;
  logic               first;
  logic               tap_good;
  logic               pat_good;
  logic [TAPBITS-1:0] run_start;
  logic [TAPBITS:0]   run_len;
  logic [TAPBITS-1:0] cand_start;
  logic [TAPBITS:0]   cand_len;
  logic               run_close;
  logic               take_best;
  logic [TAPBITS-1:0] centre_val;

  function automatic logic [NCH-1:0] ch_bit(input logic [CHW-1:0] c);
    logic [NCH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // The centre rounds towards the lower tap when the window length is even.
  function automatic logic [TAPBITS-1:0] centre_tap(input logic [TAPBITS-1:0] s,
                                                    input logic [TAPBITS:0]   len);
    logic [TAPBITS:0] half;
    half = (len - 1'b1) >> 1;
    return s + half[TAPBITS-1:0];
  endfunction

  always_comb begin
    word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch == CHW'(c)) word = data_clk_i[c*NBITS +: NBITS];
    end
    first = (smp_cnt == '0);
    // On the first sample, w0 is still being captured, so the word counts as
    // matching.
    tap_good   = first ? 1'b1 : (ok && (word == w0));
    pat_good   = (first || ok) && (word == PATTERN);
    run_start  = (cur_len == '0) ? tap : cur_start;
    run_len    = cur_len + 1'b1;
    cand_start = tap_good ? run_start : cur_start;
    cand_len   = tap_good ? run_len : cur_len;
    // A run also closes at the last tap, so a window that reaches the top
    // tap is still counted. The strict > keeps the earlier window on a tie.
    run_close  = !tap_good || (tap == LAST_TAP);
    take_best  = run_close && (cand_len > best_len);
    centre_val = centre_tap(best_start, best_len);
  end

  always_ff @(posedge clk_i or negedge rst_n_clk_i) begin
    if (!rst_n_clk_i) begin
      state         <= S_IDLE;
      ch            <= '0;
      tap           <= '0;
      slip_ph       <= 1'b0;
      slip_cnt      <= '0;
      set_cnt       <= '0;
      smp_cnt       <= '0;
      w0            <= '0;
      ok            <= 1'b0;
      cur_start     <= '0;
      cur_len       <= '0;
      best_start    <= '0;
      best_len      <= '0;
      delay_clk_o   <= '0;
      load_clk_o    <= '0;
      bitslip_clk_o <= '0;
      busy_clk_o    <= 1'b0;
      done_clk_o    <= 1'b0;
      fail_clk_o    <= '0;
      tap_clk_o     <= '0;
    end else begin
      // Strobes are raised only on the transition into LOAD or SLIP, so
      // each one lasts exactly one cycle.
      load_clk_o    <= '0;
      bitslip_clk_o <= '0;
      case (state)
        S_IDLE: begin
          if (start_clk_i) begin
            done_clk_o  <= 1'b0;
            fail_clk_o  <= '0;
            tap_clk_o   <= '0;
            busy_clk_o  <= 1'b1;
            ch          <= '0;
            tap         <= '0;
            delay_clk_o <= '0;
            load_clk_o  <= ch_bit('0);
            state       <= S_LOAD;
          end
        end

        S_LOAD: begin
          set_cnt <= '0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          if (set_cnt == SET_END) begin
            set_cnt <= '0;
            smp_cnt <= '0;
            state   <= slip_ph ? S_SCHK : S_CHECK;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          ok <= tap_good;
          if (first) w0 <= word;
          if (smp_cnt == SMP_END) begin
            smp_cnt <= '0;
            if (take_best) begin
              best_start <= cand_start;
              best_len   <= cand_len;
            end
            if (run_close) begin
              cur_len <= '0;
            end else begin
              cur_start <= run_start;
              cur_len   <= run_len;
            end
            if (tap == LAST_TAP) begin
              state <= S_CENTER;
            end else begin
              tap         <= tap + 1'b1;
              delay_clk_o <= tap + 1'b1;
              load_clk_o  <= ch_bit(ch);
              state       <= S_LOAD;
            end
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end

        S_CENTER: begin
          if (best_len == '0) begin
            fail_clk_o[ch] <= 1'b1;
            state          <= S_NEXT;
          end else begin
            tap         <= centre_val;
            delay_clk_o <= centre_val;
            load_clk_o  <= ch_bit(ch);
            for (int c = 0; c < NCH; c++) begin
              if (ch == CHW'(c)) tap_clk_o[c*TAPBITS +: TAPBITS] <= centre_val;
            end
            slip_ph  <= 1'b1;
            slip_cnt <= '0;
            state    <= S_LOAD;
          end
        end

        S_SCHK: begin
          ok <= pat_good;
          if (smp_cnt == SMP_END) begin
            smp_cnt <= '0;
            if (pat_good) begin
              state <= S_NEXT;
            end else if (slip_cnt == SLP_END) begin
              // Every slip position has been tried; the centred tap stays
              // loaded.
              fail_clk_o[ch] <= 1'b1;
              state          <= S_NEXT;
            end else begin
              bitslip_clk_o <= ch_bit(ch);
              state         <= S_SLIP;
            end
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end

        S_SLIP: begin
          slip_cnt <= slip_cnt + 1'b1;
          set_cnt  <= '0;
          state    <= S_WAIT;
        end

        S_NEXT: begin
          cur_start  <= '0;
          cur_len    <= '0;
          best_start <= '0;
          best_len   <= '0;
          slip_ph    <= 1'b0;
          slip_cnt   <= '0;
          if (ch == LAST_CH) begin
            busy_clk_o <= 1'b0;
            done_clk_o <= 1'b1;
            state      <= S_DONE;
          end else begin
            ch          <= ch + 1'b1;
            tap         <= '0;
            delay_clk_o <= '0;
            load_clk_o  <= ch_bit(ch + 1'b1);
            state       <= S_LOAD;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glitc_align_ctrl.sv
// tb_glitc_align_ctrl
//   Directed bench for glitc_align_ctrl with NCH=2, SETTLE=4, SAMPLES=8.
//   The channel model returns a stable word while the loaded tap is inside
//   the channel's good set, and a toggling word otherwise. Each bitslip
//   rotates the word left by one position.
module tb_glitc_align_ctrl;

  localparam int NCH     = 2;
  localparam int NBITS   = 4;
  localparam int TAPBITS = 5;
  localparam int SETTLE  = 4;
  localparam int SAMPLES = 8;
  localparam logic [NBITS-1:0] PAT = 4'b1010;
  localparam int TAP_CYC = 1 + SETTLE + SAMPLES;                        // 13
  localparam int NTAPS   = 1 << TAPBITS;                                // 32
  localparam int CH_GOOD = NTAPS * TAP_CYC + 1 + TAP_CYC + 1;           // 431
  localparam int CH_NOWIN = NTAPS * TAP_CYC + 1 + 1;                    // 418
  localparam int BOUND   = 4000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [NCH*NBITS-1:0]   data;
  logic [TAPBITS-1:0]     delay;
  logic [NCH-1:0]         load;
  logic [NCH-1:0]         bitslip;
  logic                   busy;
  logic                   done;
  logic [NCH-1:0]         fail;
  logic [NCH*TAPBITS-1:0] tap_o;

  glitc_align_ctrl #(
    .NCH(NCH), .NBITS(NBITS), .TAPBITS(TAPBITS), .PATTERN(PAT),
    .SETTLE(SETTLE), .SAMPLES(SAMPLES)
  ) dut (
    .clk_i(clk), .rst_n_clk_i(rst_n), .start_clk_i(start),
    .data_clk_i(data), .delay_clk_o(delay), .load_clk_o(load),
    .bitslip_clk_o(bitslip), .busy_clk_o(busy), .done_clk_o(done),
    .fail_clk_o(fail), .tap_clk_o(tap_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Channel model state
  logic [NTAPS-1:0]   good_m  [NCH];
  logic [NBITS-1:0]   base_m  [NCH];
  logic [TAPBITS-1:0] cur_tap [NCH] = '{default: '0};
  int                 rot     [NCH] = '{default: 0};
  logic               tgl = 1'b0;

  // Pulse monitor counters
  int                 n_load   [NCH] = '{default: 0};
  int                 n_slip   [NCH] = '{default: 0};
  logic [TAPBITS-1:0] last_dly [NCH] = '{default: '0};
  int                 n_done = 0;
  int                 n_viol = 0;
  int                 cyc = 0;
  int                 last_pulse = -1000;
  logic               done_q = 1'b0;

  function automatic logic [NBITS-1:0] rotl(input logic [NBITS-1:0] w, input int n);
    logic [NBITS-1:0] r;
    r = w;
    for (int i = 0; i < (n % NBITS); i++) r = {r[NBITS-2:0], r[NBITS-1]};
    return r;
  endfunction

  function automatic logic [NTAPS-1:0] win(input int lo, input int hi);
    logic [NTAPS-1:0] m;
    m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  always_comb begin
    data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (good_m[c][cur_tap[c]])
        data[c*NBITS +: NBITS] = rotl(base_m[c], rot[c]);
      else
        data[c*NBITS +: NBITS] = tgl ? base_m[c] : ~base_m[c];
    end
  end

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    tgl    <= ~tgl;
    done_q <= done;
    if (done && !done_q) n_done <= n_done + 1;
    if ($countones({load, bitslip}) > 1) n_viol <= n_viol + 1;
    if (|{load, bitslip}) begin
      if (cyc - last_pulse < SETTLE + 1) n_viol <= n_viol + 1;
      last_pulse <= cyc;
    end
    for (int c = 0; c < NCH; c++) begin
      if (load[c]) begin
        cur_tap[c]  <= delay;
        last_dly[c] <= delay;
        n_load[c]   <= n_load[c] + 1;
      end
      if (start && !busy) rot[c] <= 0;
      else if (bitslip[c]) rot[c] <= rot[c] + 1;
      if (bitslip[c]) n_slip[c] <= n_slip[c] + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [NTAPS-1:0] g0, input logic [NBITS-1:0] b0,
                       input logic [NTAPS-1:0] g1, input logic [NBITS-1:0] b1);
    good_m[0] = g0; base_m[0] = b0;
    good_m[1] = g1; base_m[1] = b1;
  endtask

  // Starts a calibration and waits for done. Optional extra start pulses
  // at cycles inj and inj+300 while busy. Then checks the outcome.
  task automatic do_run(input string tg, input int inj, input int exp_n,
                        input int t0, input int t1, input int f,
                        input int el0, input int el1, input int es0, input int es1);
    int bl0, bl1, bs0, bs1, bd, n;
    @(posedge clk); #1;
    bl0 = n_load[0]; bl1 = n_load[1]; bs0 = n_slip[0]; bs1 = n_slip[1]; bd = n_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < BOUND) begin
      @(posedge clk); #1;
      n++;
      start = (inj > 0 && (n == inj || n == inj + 300)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk({tg, ".cycles"}, n, exp_n);
    chk({tg, ".tap0"}, tap_o[TAPBITS-1:0], t0);
    chk({tg, ".tap1"}, tap_o[2*TAPBITS-1:TAPBITS], t1);
    chk({tg, ".fail"}, fail, f);
    chk({tg, ".loads0"}, n_load[0] - bl0, el0);
    chk({tg, ".loads1"}, n_load[1] - bl1, el1);
    chk({tg, ".slips0"}, n_slip[0] - bs0, es0);
    chk({tg, ".slips1"}, n_slip[1] - bs1, es1);
    repeat (3) @(posedge clk);
    #1;
    chk({tg, ".done_sticky"}, done, 1);
    chk({tg, ".busy_low"}, busy, 0);
    chk({tg, ".done_rises"}, n_done - bd, 1);
  endtask

  initial begin
    int lsnap;
    setup(win(10, 20), PAT, win(3, 5) | win(20, 27), PAT);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.fail", fail, 0);
    chk("rst.tap", tap_o, 0);
    chk("rst.delay", delay, 0);
    chk("rst.strobes", {load, bitslip}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Windows 10..20 -> 15, and 3..5 vs 20..27 -> 23
    do_run("win", 0, 2*CH_GOOD, 15, 23, 0, 33, 33, 0, 0);
    chk("win.final_delay0", last_dly[0], 15);
    chk("win.final_delay1", last_dly[1], 23);

    // One slip on ch0; tie 2..4 vs 8..10 on ch1 -> 3
    setup(win(10, 20), 4'b0101, win(2, 4) | win(8, 10), PAT);
    do_run("slip1", 0, 2*CH_GOOD + TAP_CYC, 15, 3, 0, 33, 33, 1, 0);

    // Never-matching word on ch0; all taps good on ch1 -> 15
    setup(win(10, 20), 4'b1111, win(0, 31), PAT);
    do_run("slipfail", 0, 2*CH_GOOD + 3*TAP_CYC, 15, 15, 1, 33, 33, 3, 0);

    // No good taps on ch0; ch1 good only at tap 31
    setup('0, PAT, win(31, 31), PAT);
    do_run("nowin", 0, CH_NOWIN + CH_GOOD, 0, 31, 1, 32, 33, 0, 0);

    // Start pulses while busy change nothing
    setup(win(10, 20), PAT, win(3, 5) | win(20, 27), PAT);
    do_run("busystart", 50, 2*CH_GOOD, 15, 23, 0, 33, 33, 0, 0);

    // Reset in the middle of a scan
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart.first_load", load, 2'b01);
    chk("restart.first_delay", delay, 0);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.delay", delay, 0);
    chk("midrst.tap", tap_o, 0);
    chk("midrst.strobes", {load, bitslip}, 0);
    lsnap = n_load[0] + n_load[1] + n_slip[0] + n_slip[1];
    repeat (20) @(posedge clk);
    #1;
    chk("midrst.no_pulses", n_load[0] + n_load[1] + n_slip[0] + n_slip[1], lsnap);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_run("afterrst", 0, 2*CH_GOOD, 15, 23, 0, 33, 33, 0, 0);

    chk("pulse_rules", n_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
